// File: rtl/dot_vector_loader.sv
// Serial-to-parallel loader: packs (a_i, b_i) element pairs into N-element vectors
// and holds each frame stable until the dot-product stage consumes it.
// Optional frame/short-frame counters are enabled with `define LOADER_STATS_EN.
module dot_vector_loader #(
  parameter int N  = 16,
  parameter int W  = 32,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_last,
  output logic [W*N-1:0] vec_a,
  output logic [W*N-1:0] vec_b,
  output logic [CW-1:0]  vec_len,
  output logic           vec_valid,
  input  logic           vec_ready
`ifdef LOADER_STATS_EN
  ,
  output logic [15:0]    frame_count,
  output logic [15:0]    short_count
`endif
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_idx;
  logic [W*N-1:0] r_vec_a;
  logic [W*N-1:0] r_vec_b;
  logic [CW-1:0]  r_vec_len;
  logic           w_accept;
  logic           w_frame_done;
  logic           w_handshake;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_frame_done = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      FILL: begin
        w_accept = in_valid;
        if (in_valid && (in_last || r_idx == CW'(N - 1))) begin
          w_frame_done = 1'b1;
          w_state_next = FULL;
        end
      end
      FULL: begin
        if (vec_ready) begin
          w_handshake  = 1'b1;
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // NOTE: the vector slots are reset and cleared after every frame on purpose:
  // unwritten slots of a short frame must read as zero for the dot product.
  always_ff @(posedge clk) begin
    if (rst || w_handshake) begin
      r_idx     <= '0;
      r_vec_a   <= '0;
      r_vec_b   <= '0;
      r_vec_len <= '0;
    end else if (w_accept) begin
      r_vec_a[W*int'(r_idx) +: W] <= in_a;
      r_vec_b[W*int'(r_idx) +: W] <= in_b;
      // idx parks on the final slot until the handshake clears it
      if (w_frame_done) r_vec_len <= r_idx + CW'(1);
      else              r_idx     <= r_idx + CW'(1);
    end
  end

  assign in_ready  = (r_state == FILL);
  assign vec_valid = (r_state == FULL);
  assign vec_a     = r_vec_a;
  assign vec_b     = r_vec_b;
  assign vec_len   = r_vec_len;

`ifdef LOADER_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_short_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_count <= '0;
      r_short_count <= '0;
    end else if (w_handshake) begin
      r_frame_count <= r_frame_count + 16'd1;
      if (r_vec_len < CW'(N)) r_short_count <= r_short_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
  assign short_count = r_short_count;
`endif

endmodule

// File: tb/tb_dot_vector_loader.sv
// Directed bench for dot_vector_loader: frame table plus hand-written sequences for
// backpressure, missing in_last and mid-frame reset (counters when LOADER_STATS_EN).
module tb_dot_vector_loader;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int CW = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_last;
  logic [W*N-1:0] vec_a;
  logic [W*N-1:0] vec_b;
  logic [CW-1:0]  vec_len;
  logic           vec_valid;
  logic           vec_ready;
`ifdef LOADER_STATS_EN
  logic [15:0]    frame_count;
  logic [15:0]    short_count;
`endif

  dot_vector_loader #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .vec_a     (vec_a),
    .vec_b     (vec_b),
    .vec_len   (vec_len),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready)
`ifdef LOADER_STATS_EN
    ,
    .frame_count (frame_count),
    .short_count (short_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int valid_rises = 0;
  logic vv_prev = 1'b0;

  // counts every presented frame, including any that should never have appeared
  always @(negedge clk) begin
    if (vec_valid && !vv_prev) valid_rises++;
    vv_prev = vec_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n;
    int          a0;
    int          am;
    int          b0;
    int          bm;
    int          exp_len;
    logic [63:0] exp_dot;
  } frame_t;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W*N-1:0] build(input int base, input int step, input int n);
    logic [W*N-1:0] v = '0;
    for (int i = 0; i < n; i++) v[W*i +: W] = W'(base + step * i);
    return v;
  endfunction

  function automatic logic [63:0] dot(input logic [W*N-1:0] a, input logic [W*N-1:0] b);
    logic [63:0] s = '0;
    for (int i = 0; i < N; i++) s += 64'(a[W*i +: W]) * 64'(b[W*i +: W]);
    return s;
  endfunction

  // Called one ns after a rising edge; returns one ns after the accepting edge.
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready never rose, got 0 expected 1");
    end
  endtask

  task automatic send_frame(input int a0, input int am, input int b0, input int bm,
                            input int n, input bit last_on_final);
    for (int i = 0; i < n; i++)
      send_beat(W'(a0 + am * i), W'(b0 + bm * i), last_on_final && (i == n - 1));
  endtask

  // Call at the negedge where the frame should be presented.
  task automatic check_frame(input string name, input int a0, input int am, input int b0,
                             input int bm, input int n, input int exp_len);
    check({name, "_valid"}, 512'(vec_valid), 512'(1));
    check({name, "_len"},   512'(vec_len),   512'(exp_len));
    check({name, "_vec_a"}, 512'(vec_a),     512'(build(a0, am, n)));
    check({name, "_vec_b"}, 512'(vec_b),     512'(build(b0, bm, n)));
    check({name, "_in_ready_low"}, 512'(in_ready), 512'(0));
  endtask

  frame_t         tbl[2];
  logic [W*N-1:0] held_a;
  logic [W*N-1:0] exp_v;

  initial begin
    tbl[0] = '{n: 16, a0: 1, am: 1, b0: 2,  bm: 2,  exp_len: 16, exp_dot: 64'd2992};
    tbl[1] = '{n: 3,  a0: 1, am: 1, b0: 10, bm: 10, exp_len: 3,  exp_dot: 64'd140};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; vec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  512'(in_ready),  512'(1));
    check("rst_vec_valid", 512'(vec_valid), 512'(0));
    check("rst_vec_len",   512'(vec_len),   512'(0));
    check("rst_vec_a",     512'(vec_a),     512'(0));
    check("rst_vec_b",     512'(vec_b),     512'(0));
    @(posedge clk); #1;

    // full and short frames, downstream always ready
    vec_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send_frame(tbl[k].a0, tbl[k].am, tbl[k].b0, tbl[k].bm, tbl[k].n, 1'b1);
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      check_frame($sformatf("tbl%0d", k), tbl[k].a0, tbl[k].am, tbl[k].b0, tbl[k].bm,
                  tbl[k].n, tbl[k].exp_len);
      check($sformatf("tbl%0d_dot", k), 512'(dot(vec_a, vec_b)), 512'(tbl[k].exp_dot));
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready_back", k), 512'(in_ready),  512'(1));
      check($sformatf("tbl%0d_cleared_valid", k), 512'(vec_valid), 512'(0));
      check($sformatf("tbl%0d_cleared_a", k),     512'(vec_a),     512'(0));
      @(posedge clk); #1;
    end

    // 17 beats without in_last: the frame closes at 16, beat 17 waits for the next frame
    send_frame(100, 1, 200, 3, 16, 1'b0);
    in_valid = 1'b1; in_a = 32'h1717; in_b = 32'h7171; in_last = 1'b0;
    @(negedge clk);
    check_frame("nolast", 100, 1, 200, 3, 16, 16);
    send_beat(32'h1717, 32'h7171, 1'b0);
`ifdef LOADER_STATS_EN
    check("stats_frame_3", 512'(frame_count), 512'(3));
    check("stats_short_1", 512'(short_count), 512'(1));
`endif
    send_beat(32'd99, 32'd98, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    exp_v = '0; exp_v[0 +: W] = 32'h1717; exp_v[W +: W] = 32'd99;
    check("beat17_vec_a", 512'(vec_a), 512'(exp_v));
    exp_v = '0; exp_v[0 +: W] = 32'h7171; exp_v[W +: W] = 32'd98;
    check("beat17_vec_b", 512'(vec_b), 512'(exp_v));
    check("beat17_len",   512'(vec_len), 512'(2));
    @(posedge clk); #1;

    // backpressure: frame held for 5 cycles while the source keeps offering a beat
    vec_ready = 1'b0;
    send_frame(7, 1, 3, 1, 4, 1'b1);
    in_valid = 1'b1; in_a = 32'hDEAD; in_b = 32'hBEEF; in_last = 1'b1;
    held_a = build(7, 1, 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_vec_a", c),    512'(vec_a),     512'(held_a));
      check($sformatf("bp%0d_vec_b", c),    512'(vec_b),     512'(build(3, 1, 4)));
      check($sformatf("bp%0d_len", c),      512'(vec_len),   512'(4));
      check($sformatf("bp%0d_valid", c),    512'(vec_valid), 512'(1));
      check($sformatf("bp%0d_in_ready", c), 512'(in_ready),  512'(0));
      @(posedge clk); #1;
    end
    vec_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_valid",    512'(vec_valid), 512'(0));
    check("bp_release_in_ready", 512'(in_ready),  512'(1));
    check("bp_release_len",      512'(vec_len),   512'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check_frame("bp_next", 32'hDEAD, 0, 32'hBEEF, 0, 1, 1);
    @(posedge clk); #1;
`ifdef LOADER_STATS_EN
    check("stats_frame_6", 512'(frame_count), 512'(6));
    check("stats_short_4", 512'(short_count), 512'(4));
`endif

    // reset after 7 accepted beats discards the partial frame
    send_frame(1, 1, 1, 1, 7, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_in_ready",  512'(in_ready),  512'(1));
    check("mrst_vec_valid", 512'(vec_valid), 512'(0));
    check("mrst_vec_a",     512'(vec_a),     512'(0));
`ifdef LOADER_STATS_EN
    check("stats_rst_frame", 512'(frame_count), 512'(0));
    check("stats_rst_short", 512'(short_count), 512'(0));
`endif
    @(posedge clk); #1;
    send_frame(5, 1, 5, 1, 2, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check_frame("post_rst", 5, 1, 5, 1, 2, 2);
    check("post_rst_dot", 512'(dot(vec_a, vec_b)), 512'(61));
    @(posedge clk); #1;
    @(negedge clk);
`ifdef LOADER_STATS_EN
    check("stats_post_frame", 512'(frame_count), 512'(1));
    check("stats_post_short", 512'(short_count), 512'(1));
`endif
    check("valid_pulse_count", 512'(valid_rises), 512'(7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
